// File: rtl/mem_uart_reader.sv
// Memory-to-UART readback engine: HEADER, each word MSB-byte first, TERMINATOR.
// Define CHECKSUM_EN to insert an XOR-of-payload byte just before TERMINATOR.
module mem_uart_reader #(
    parameter int              WIDTH      = 32,
    parameter int              DEPTH      = 8,
    parameter int              DBITS      = 8,
    parameter logic [DBITS-1:0] HEADER     = 'h0C,
    parameter logic [DBITS-1:0] TERMINATOR = 'h0A
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DEPTH-1:0] base_addr,
    input  logic [DEPTH:0]   word_count,
    output logic [DEPTH-1:0] mem_address,
    output logic             mem_rd_en,
    input  logic [WIDTH-1:0] mem_q,
    output logic [DBITS-1:0] tx_data,
    output logic             tx_start,
    input  logic             tx_done,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    localparam int NBYTES = WIDTH / DBITS;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);
    localparam logic [DEPTH:0]  ONE_WORD = (DEPTH+1)'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        RD   = 3'd2,
        LOAD = 3'd3,
        BYTE = 3'd4,
        TERM = 3'd5,
        FIN  = 3'd6
`ifdef CHECKSUM_EN
        ,
        CSUM = 3'd7
`endif
    } state_t;

`ifdef CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = CSUM;
`else
    localparam state_t AFTER_PAYLOAD = TERM;
`endif

    state_t           state;
    logic [DEPTH-1:0] addr_cnt;
    logic [DEPTH:0]   remaining;
    logic [WIDTH-1:0] shift;
    logic [IDXW-1:0]  byte_idx;
`ifdef CHECKSUM_EN
    logic [DBITS-1:0] csum;
`endif

    assign dbg_state = state;

    // Byte handshake: tx_start is the valid, tx_done the one-cycle ack. tx_data is
    // stable while tx_start=1; an ack only counts while tx_start=1; after an ack
    // tx_start drops for at least one cycle before the next byte is presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addr_cnt    <= '0;
            remaining   <= '0;
            shift       <= '0;
            byte_idx    <= '0;
            mem_address <= '0;
            mem_rd_en   <= 1'b0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt  <= base_addr;
                        remaining <= word_count;
                        busy      <= 1'b1;
                        state     <= HDR;
`ifdef CHECKSUM_EN
                        csum      <= '0;
`endif
                    end
                end
                HDR: begin
                    if (!tx_start) begin
                        tx_start <= 1'b1;
                        tx_data  <= HEADER;
                    end else if (tx_done) begin
                        tx_start <= 1'b0;
                        if (remaining != '0) begin
                            mem_rd_en   <= 1'b1;
                            mem_address <= addr_cnt;
                            state       <= RD;
                        end else begin
                            state <= AFTER_PAYLOAD;
                        end
                    end
                end
                // The read strobe was raised on entry; memory data is valid during LOAD.
                RD: state <= LOAD;
                LOAD: begin
                    shift    <= mem_q;
                    byte_idx <= '0;
                    state    <= BYTE;
                end
                BYTE: begin
                    if (!tx_start) begin
                        tx_start <= 1'b1;
                        tx_data  <= shift[WIDTH-1 -: DBITS];
                    end else if (tx_done) begin
                        tx_start <= 1'b0;
                        shift    <= shift << DBITS;
`ifdef CHECKSUM_EN
                        csum     <= csum ^ shift[WIDTH-1 -: DBITS];
`endif
                        if (byte_idx == LAST_IDX) begin
                            byte_idx  <= '0;
                            addr_cnt  <= addr_cnt + 1'b1;
                            remaining <= remaining - 1'b1;
                            if (remaining != ONE_WORD) begin
                                mem_rd_en   <= 1'b1;
                                mem_address <= addr_cnt + 1'b1;
                                state       <= RD;
                            end else begin
                                state <= AFTER_PAYLOAD;
                            end
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
`ifdef CHECKSUM_EN
                CSUM: begin
                    if (!tx_start) begin
                        tx_start <= 1'b1;
                        tx_data  <= csum;
                    end else if (tx_done) begin
                        tx_start <= 1'b0;
                        state    <= TERM;
                    end
                end
`endif
                TERM: begin
                    if (!tx_start) begin
                        tx_start <= 1'b1;
                        tx_data  <= TERMINATOR;
                    end else if (tx_done) begin
                        tx_start <= 1'b0;
                        state    <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_uart_reader.sv
// Randomized bench for mem_uart_reader: memory and Transmitter models, a frame-level
// reference built from the frame rules, and a byte/address scoreboard.
module tb_mem_uart_reader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int DBITS = 8;
  localparam int NB    = WIDTH / DBITS;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [DEPTH-1:0] base_addr = '0;
  logic [DEPTH:0]   word_count = '0;
  logic [DEPTH-1:0] mem_address;
  logic             mem_rd_en;
  logic [WIDTH-1:0] mem_q = '0;
  logic [DBITS-1:0] tx_data;
  logic             tx_start;
  logic             tx_done = 1'b0;
  logic             busy;
  logic             done;
  logic [2:0]       dbg_state;

  mem_uart_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .mem_address(mem_address), .mem_rd_en(mem_rd_en),
    .mem_q(mem_q), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] mem [256];
  logic [DBITS-1:0] exp_q[$];
  logic [DBITS-1:0] got_q[$];
  logic [DEPTH-1:0] exp_addr_q[$];
  logic [DEPTH-1:0] rd_q[$];
  int   done_cnt = 0;
  int   stab_err = 0;
  int   hs_err = 0;
  int   tx_lat = 4;
  bit   spur_en = 1'b0;
  logic prev_start = 1'b0;
  logic prev_ack = 1'b0;
  logic [DBITS-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory with one-cycle registered read
  always @(posedge clk) begin
    if (mem_rd_en) mem_q <= mem[mem_address];
  end

  // Transmitter model: ack tx_lat cycles after seeing a request, optionally spurious acks
  always begin
    @(negedge clk);
    if (reset && tx_start) begin
      repeat (tx_lat) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end else if (reset && spur_en && $urandom_range(0, 2) == 0) begin
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  end

  // monitor: sampled just after the falling edge, when all inputs for the next edge are settled
  always @(negedge clk) begin
    #1;
    if (reset) begin
      if (tx_start && !prev_start) got_q.push_back(tx_data);
      if (tx_start && prev_start && tx_data != prev_data) stab_err++;
      if (prev_ack && tx_start) hs_err++;
      if (mem_rd_en) rd_q.push_back(mem_address);
      if (done) done_cnt++;
    end
    prev_start = tx_start;
    prev_data  = tx_data;
    prev_ack   = tx_start && tx_done;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // reference frame: header, words MSB byte first from wrapped addresses, [xor], terminator
  task automatic build_model(input int base, input int count);
    logic [DBITS-1:0] cs;
    logic [DBITS-1:0] bt;
    logic [WIDTH-1:0] w;
    int a;
    cs = '0;
    exp_q.delete();
    exp_addr_q.delete();
    exp_q.push_back(8'h0C);
    for (int i = 0; i < count; i++) begin
      a = (base + i) % 256;
      exp_addr_q.push_back(8'(a));
      w = mem[a];
      for (int b = NB - 1; b >= 0; b--) begin
        bt = 8'((w >> (8 * b)) & 32'hFF);
        exp_q.push_back(bt);
        cs = cs ^ bt;
      end
    end
`ifdef CHECKSUM_EN
    exp_q.push_back(cs);
`endif
    exp_q.push_back(8'h0A);
  endtask

  task automatic clear_sb();
    got_q.delete();
    rd_q.delete();
    done_cnt = 0;
    stab_err = 0;
    hs_err = 0;
  endtask

  task automatic run_frame(input int base, input int count, input int lat, input bit spur, input bit extra);
    int budget;
    int cyc;
    build_model(base, count);
    clear_sb();
    tx_lat = lat;
    spur_en = spur;
    tick();
    base_addr = 8'(base);
    word_count = 9'(count);
    start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = 8'($urandom);
    word_count = 9'($urandom_range(1, 4));
    check("busy_acc", 64'(busy), 64'(1));
    check("lat_early", 64'(tx_start), 64'(0));
    tick();
    check("lat_hdr", 64'(tx_start), 64'(1));
    budget = exp_q.size() * (lat + 6) + count * 4 + 50;
    cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      start = (extra && cyc == 6) ? 1'b1 : 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    check("done_timeout", 64'(done_cnt != 0), 64'(1));
    check("busy_fin", 64'(busy), 64'(0));
    repeat (8 + lat) tick();
    spur_en = 1'b0;
    check("done_cnt", 64'(done_cnt), 64'(1));
    check("n_bytes", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("byte%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    check("n_reads", 64'(rd_q.size()), 64'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < rd_q.size(); i++)
      check($sformatf("addr%0d", i), 64'(rd_q[i]), 64'(exp_addr_q[i]));
    check("tx_data_stable", 64'(stab_err), 64'(0));
    check("tx_start_drop", 64'(hs_err), 64'(0));
  endtask

  initial begin
    int base;
    int count;
    int lat;
    int cyc;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    // reset state
    repeat (3) tick();
    check("rst_tx_start", 64'(tx_start), 64'(0));
    check("rst_tx_data", 64'(tx_data), 64'(0));
    check("rst_rd_en", 64'(mem_rd_en), 64'(0));
    check("rst_addr", 64'(mem_address), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    reset = 1'b1;
    repeat (2) tick();

    // single word
    mem[3] = 32'hDEADBEEF;
    run_frame(3, 1, 20, 1'b0, 1'b0);
    // empty frame
    run_frame(17, 0, 3, 1'b0, 1'b0);
    // address wrap
    mem[255] = 32'h01020304;
    mem[0] = 32'hA0B0C0D0;
    run_frame(255, 2, 2, 1'b0, 1'b0);
    // start while busy and spurious acks
    run_frame(10, 2, 8, 1'b1, 1'b1);

    // reset during the second payload byte
    tx_lat = 20;
    clear_sb();
    tick();
    base_addr = 8'd3;
    word_count = 9'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (got_q.size() < 3 && cyc < 300) begin
      tick();
      cyc++;
    end
    check("rst_reach_byte2", 64'(got_q.size()), 64'(3));
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("mid_rst_tx_start", 64'(tx_start), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_rd_en", 64'(mem_rd_en), 64'(0));
    check("mid_rst_state", 64'(dbg_state), 64'(0));
    repeat (3) tick();
    reset = 1'b1;
    repeat (40) tick();
    run_frame(0, 1, 3, 1'b0, 1'b0);

    // full memory dump
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    run_frame($urandom_range(0, 255), 256, 0, 1'b0, 1'b0);

    // random frames
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < 16; i++) mem[$urandom_range(0, 255)] = $urandom;
      base = $urandom_range(0, 255);
      count = $urandom_range(0, 6);
      lat = $urandom_range(0, 7);
      run_frame(base, count, lat, 1'($urandom_range(0, 1)), lat >= 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
